// File: rtl/router_register.sv
// Router datapath register: captures the header, forwards bytes to the FIFO,
// holds a byte across FIFO-full and checks the packet's XOR parity.
module router_register (
  input  logic       clk,
  input  logic       rstn,
  input  logic       pkt_valid,
  input  logic [7:0] data_in,
  input  logic       fifo_full,
  input  logic       rst_int_reg,
  input  logic       detect_add,
  input  logic       ld_state,
  input  logic       laf_state,
  input  logic       full_state,
  input  logic       lfd_state,
  output logic       parity_done,
  output logic       low_pkt_valid,
  output logic       err,
  output logic [7:0] dout
);

  logic [7:0] r_header_byte;
  logic [7:0] r_fifo_full_byte;
  logic [7:0] r_internal_parity;
  logic [7:0] r_packet_parity;
  logic [7:0] r_dout;
  logic       r_parity_done;
  logic       r_low_pkt_valid;
  logic       r_err;

  logic w_hdr_load;
  logic w_parity_byte;

  // Address 2'b11 is not a valid destination, so such a header is ignored.
  assign w_hdr_load    = detect_add && pkt_valid && (data_in[1:0] != 2'b11);
  assign w_parity_byte = ld_state && !pkt_valid;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_header_byte    <= 8'h00;
      r_fifo_full_byte <= 8'h00;
      r_dout           <= 8'h00;
    end else begin
      if (w_hdr_load)
        r_header_byte <= data_in;
      if (ld_state && fifo_full)
        r_fifo_full_byte <= data_in;
      if (lfd_state)
        r_dout <= r_header_byte;
      else if (ld_state && !fifo_full)
        r_dout <= data_in;
      else if (laf_state)
        r_dout <= r_fifo_full_byte;
    end
  end

  // Parity accumulation and status flags; detect_add starts a fresh packet.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_internal_parity <= 8'h00;
      r_packet_parity   <= 8'h00;
      r_parity_done     <= 1'b0;
      r_low_pkt_valid   <= 1'b0;
      r_err             <= 1'b0;
    end else begin
      if (detect_add)
        r_internal_parity <= 8'h00;
      else if (lfd_state)
        r_internal_parity <= r_internal_parity ^ r_header_byte;
      else if (ld_state && pkt_valid && !full_state)
        r_internal_parity <= r_internal_parity ^ data_in;

      if (detect_add)
        r_packet_parity <= 8'h00;
      else if (w_parity_byte)
        r_packet_parity <= data_in;

      if (rst_int_reg)
        r_low_pkt_valid <= 1'b0;
      else if (w_parity_byte)
        r_low_pkt_valid <= 1'b1;

      if (detect_add)
        r_parity_done <= 1'b0;
      else if ((w_parity_byte && !fifo_full) ||
               (laf_state && r_low_pkt_valid && !r_parity_done))
        r_parity_done <= 1'b1;

      if (detect_add)
        r_err <= 1'b0;
      else if (r_parity_done)
        r_err <= (r_internal_parity != r_packet_parity);
    end
  end

  assign dout          = r_dout;
  assign parity_done   = r_parity_done;
  assign low_pkt_valid = r_low_pkt_valid;
  assign err           = r_err;

endmodule

// File: tb/tb_router_register.sv
// Self-checking bench for router_register: reset, good/bad packets,
// FIFO-full hold, flag clears, invalid address and mid-packet reset.
module tb_router_register;

  logic       clk;
  logic       rstn;
  logic       pkt_valid;
  logic [7:0] data_in;
  logic       fifo_full;
  logic       rst_int_reg;
  logic       detect_add;
  logic       ld_state;
  logic       laf_state;
  logic       full_state;
  logic       lfd_state;
  logic       parity_done;
  logic       low_pkt_valid;
  logic       err;
  logic [7:0] dout;

  logic [7:0] exp_q[$];
  logic [7:0] exp_b;
  int         n_cmp;
  int         n_bad;

  router_register dut (
    .clk          (clk),
    .rstn         (rstn),
    .pkt_valid    (pkt_valid),
    .data_in      (data_in),
    .fifo_full    (fifo_full),
    .rst_int_reg  (rst_int_reg),
    .detect_add   (detect_add),
    .ld_state     (ld_state),
    .laf_state    (laf_state),
    .full_state   (full_state),
    .lfd_state    (lfd_state),
    .parity_done  (parity_done),
    .low_pkt_valid(low_pkt_valid),
    .err          (err),
    .dout         (dout)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // driver tasks: inputs change 1 time unit after the rising edge,
  // outputs are sampled at the same offset after the following edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic da, input logic lfd, input logic ld,
                       input logic laf, input logic fs, input logic pv,
                       input logic ff, input logic rir, input logic [7:0] d);
    detect_add  = da;
    lfd_state   = lfd;
    ld_state    = ld;
    laf_state   = laf;
    full_state  = fs;
    pkt_valid   = pv;
    fifo_full   = ff;
    rst_int_reg = rir;
    data_in     = d;
    step();
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 8'h00);
  endtask

  task automatic test_reset();
    detect_add = 0; lfd_state = 0; ld_state = 0; laf_state = 0;
    full_state = 0; pkt_valid = 0; fifo_full = 0; rst_int_reg = 0;
    data_in = 8'h00;
    rstn = 1'b1;
    #2 rstn = 1'b0;
    #1;
    n_cmp++;
    if ({dout, err, parity_done, low_pkt_valid} !== 11'h0) begin
      n_bad++;
      $display("FAIL reset_async: actual=%h/%b/%b/%b required=00/0/0/0",
               dout, err, parity_done, low_pkt_valid);
    end
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    step();
    n_cmp++;
    if ({dout, err, parity_done, low_pkt_valid} !== 11'h0) begin
      n_bad++;
      $display("FAIL reset_release: actual=%h/%b/%b/%b required=00/0/0/0",
               dout, err, parity_done, low_pkt_valid);
    end
  endtask

  task automatic run_packet(input logic bad, input string tag);
    logic [7:0] pay[5];
    logic [7:0] par;
    logic [7:0] last;
    par = 8'h16;
    for (int i = 0; i < 5; i++) begin
      pay[i] = 8'($urandom_range(0, 255));
      par    = par ^ pay[i];
    end
    if (bad && par == 8'd46) begin
      pay[0] = pay[0] ^ 8'h01;
      par    = par ^ 8'h01;
    end
    last = bad ? 8'd46 : par;

    drive(1, 0, 0, 0, 0, 1, 0, 0, 8'h16);
    n_cmp++;
    if (parity_done !== 1'b0 || err !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_detect: actual pd=%b err=%b required pd=0 err=0",
               tag, parity_done, err);
    end

    exp_q.push_back(8'h16);
    drive(0, 1, 0, 0, 0, 1, 0, 0, 8'h00);
    exp_b = exp_q.pop_front();
    n_cmp++;
    if (dout !== exp_b) begin
      n_bad++;
      $display("FAIL %s_header: actual=%h required=%h", tag, dout, exp_b);
    end

    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(pay[i]);
      drive(0, 0, 1, 0, 0, 1, 0, 0, pay[i]);
      exp_b = exp_q.pop_front();
      n_cmp++;
      if (dout !== exp_b) begin
        n_bad++;
        $display("FAIL %s_payload%0d: actual=%h required=%h", tag, i, dout, exp_b);
      end
    end

    exp_q.push_back(last);
    drive(0, 0, 1, 0, 0, 0, 0, 0, last);
    exp_b = exp_q.pop_front();
    n_cmp++;
    if (dout !== exp_b || parity_done !== 1'b1 || low_pkt_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL %s_parity_byte: actual dout=%h pd=%b lpv=%b required dout=%h pd=1 lpv=1",
               tag, dout, parity_done, low_pkt_valid, exp_b);
    end

    idle();
    n_cmp++;
    if (err !== bad) begin
      n_bad++;
      $display("FAIL %s_err: actual=%b required=%b", tag, err, bad);
    end
  endtask

  task automatic test_good_packet();
    run_packet(1'b0, "good");
  endtask

  task automatic test_bad_packet();
    run_packet(1'b1, "bad");
  endtask

  task automatic test_clear();
    // detect_add together with a parity-byte load: the clears must win
    drive(1, 0, 1, 0, 0, 0, 0, 0, 8'h55);
    n_cmp++;
    if (parity_done !== 1'b0 || err !== 1'b0) begin
      n_bad++;
      $display("FAIL clear_detect: actual pd=%b err=%b required pd=0 err=0",
               parity_done, err);
    end
    // rst_int_reg together with the low_pkt_valid set condition
    drive(0, 0, 1, 0, 0, 0, 0, 1, 8'h00);
    n_cmp++;
    if (low_pkt_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL clear_lpv: actual=%b required=0", low_pkt_valid);
    end
    idle();
    n_cmp++;
    if (low_pkt_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL clear_lpv_hold: actual=%b required=0", low_pkt_valid);
    end
  endtask

  task automatic test_fifo_full();
    exp_q.push_back(8'h3C);
    drive(0, 0, 1, 0, 0, 1, 0, 0, 8'h3C);
    exp_b = exp_q.pop_front();
    n_cmp++;
    if (dout !== exp_b) begin
      n_bad++;
      $display("FAIL full_pre: actual=%h required=%h", dout, exp_b);
    end
    drive(0, 0, 1, 0, 0, 1, 1, 0, 8'hA5);
    n_cmp++;
    if (dout !== 8'h3C) begin
      n_bad++;
      $display("FAIL full_hold: actual=%h required=3c", dout);
    end
    exp_q.push_back(8'hA5);
    drive(0, 0, 0, 1, 1, 1, 0, 0, 8'h00);
    exp_b = exp_q.pop_front();
    n_cmp++;
    if (dout !== exp_b) begin
      n_bad++;
      $display("FAIL full_laf: actual=%h required=%h", dout, exp_b);
    end
    idle();
  endtask

  task automatic test_invalid_addr();
    drive(1, 0, 0, 0, 0, 1, 0, 0, 8'h2D);
    drive(1, 0, 0, 0, 0, 1, 0, 0, 8'h17);
    exp_q.push_back(8'h2D);
    drive(0, 1, 0, 0, 0, 1, 0, 0, 8'h00);
    exp_b = exp_q.pop_front();
    n_cmp++;
    if (dout !== exp_b) begin
      n_bad++;
      $display("FAIL invalid_addr: actual=%h required=%h", dout, exp_b);
    end
    idle();
  endtask

  task automatic test_mid_packet_reset();
    drive(1, 0, 0, 0, 0, 1, 0, 0, 8'h16);
    drive(0, 1, 0, 0, 0, 1, 0, 0, 8'h00);
    drive(0, 0, 1, 0, 0, 1, 0, 0, 8'h81);
    drive(0, 0, 1, 0, 0, 0, 0, 0, 8'h42);
    detect_add = 0; ld_state = 0;
    #2 rstn = 1'b0;
    #1;
    n_cmp++;
    if ({dout, err, parity_done, low_pkt_valid} !== 11'h0) begin
      n_bad++;
      $display("FAIL mid_reset: actual=%h/%b/%b/%b required=00/0/0/0",
               dout, err, parity_done, low_pkt_valid);
    end
    @(negedge clk);
    rstn = 1'b1;
    step();
    // header_byte was cleared too, so an immediate lfd shows 00
    exp_q.push_back(8'h00);
    drive(0, 1, 0, 0, 0, 1, 0, 0, 8'h00);
    exp_b = exp_q.pop_front();
    n_cmp++;
    if (dout !== exp_b) begin
      n_bad++;
      $display("FAIL mid_reset_header: actual=%h required=%h", dout, exp_b);
    end
    idle();
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_good_packet();
    test_bad_packet();
    test_clear();
    test_fifo_full();
    test_invalid_addr();
    test_mid_packet_reset();
    test_good_packet();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: actual=%0d required=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
